// File: rtl/syria_pkg.sv
// Shared constants and FSM state type for the game-state packet UART path.
package syria_pkg;
    localparam int PKT_BYTES = 22;
    localparam int PKT_W = 8 * PKT_BYTES;
    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD = 115_200;
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser with baud counter; a byte offered during the final stop
// cycle is chained straight into the next start bit with no idle gap.
module uart_byte_tx
    import syria_pkg::*;
#(
    parameter int DIVISOR = syria_pkg::CLK_HZ / syria_pkg::BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       busy,
    output logic       stop_end,
    output logic       txd
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

    tx_state_t     state_reg, state_next;
    logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          txd_reg, txd_next;
    logic          bit_end;

    assign bit_end    = (baud_cnt_reg == CNT_LAST);
    assign busy       = (state_reg != IDLE);
    assign stop_end   = (state_reg == STOP) && bit_end;
    assign byte_ready = (state_reg == IDLE) || stop_end;
    assign txd        = txd_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            txd_reg      <= txd_next;
        end
    end

    // txd is registered with the level of the bit being entered, so the line
    // changes on the same edge as the state.
    always_comb begin
        state_next    = state_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        txd_next      = txd_reg;
        baud_cnt_next = (state_reg == IDLE || bit_end) ? '0 : baud_cnt_reg + CW'(1);
        case (state_reg)
            IDLE: begin
                txd_next = 1'b1;
                if (byte_valid) begin
                    state_next = START;
                    txd_next   = 1'b0;
                    shift_next = byte_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    txd_next     = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        txd_next     = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_valid) begin
                        state_next = START;
                        txd_next   = 1'b0;
                        shift_next = byte_data;
                    end else begin
                        state_next = IDLE;
                        txd_next   = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: rtl/packet_uart_tx.sv
// Latches a game-state packet on send and streams it (optionally after a sync
// header) as back-to-back UART frames, reporting busy and a done pulse.
module packet_uart_tx #(
    parameter int         CLK_HZ    = syria_pkg::CLK_HZ,
    parameter int         BAUD      = syria_pkg::BAUD,
    parameter int         PKT_BYTES = syria_pkg::PKT_BYTES,
    parameter int         HDR_EN    = 1,
    parameter logic [7:0] HDR_BYTE  = syria_pkg::HDR_BYTE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*PKT_BYTES-1:0] packet,
    input  logic                   send,
    output logic                   busy,
    output logic                   done,
    output logic                   TxD
);
    localparam int DIVISOR   = CLK_HZ / BAUD;
    localparam int PKT_W     = 8 * PKT_BYTES;
    localparam int NUM_BYTES = PKT_BYTES + ((HDR_EN != 0) ? 1 : 0);
    localparam int IW        = $clog2(PKT_BYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

    logic [PKT_W-1:0] pkt_buf_reg;
    logic [IW-1:0]    byte_idx_reg;
    logic             done_reg;
    logic             byte_valid, byte_ready, stop_end, last_byte, load;
    logic [7:0]       byte_data;

    uart_byte_tx #(.DIVISOR(DIVISOR)) u_byte_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .busy       (busy),
        .stop_end   (stop_end),
        .txd        (TxD)
    );

    // While idle the first byte comes straight from the port; afterwards the
    // latched buffer is shifted so its top byte is always the next payload byte.
    always_comb begin
        last_byte = (byte_idx_reg == LAST_IDX);
        if (!busy) begin
            byte_valid = send;
            byte_data  = (HDR_EN != 0) ? HDR_BYTE : packet[PKT_W-1 -: 8];
        end else begin
            byte_valid = stop_end && !last_byte;
            byte_data  = pkt_buf_reg[PKT_W-1 -: 8];
        end
        load = byte_valid && byte_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_buf_reg  <= '0;
            byte_idx_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= stop_end && last_byte;
            if (load) begin
                if (!busy) begin
                    pkt_buf_reg  <= (HDR_EN != 0) ? packet : {packet[PKT_W-9:0], 8'h00};
                    byte_idx_reg <= '0;
                end else begin
                    pkt_buf_reg  <= {pkt_buf_reg[PKT_W-9:0], 8'h00};
                    byte_idx_reg <= byte_idx_reg + IW'(1);
                end
            end
        end
    end

    assign done = done_reg;
endmodule

// File: tb/tb_packet_uart_tx.sv
// Directed bench: two instances (header on / header off) at a short divisor,
// decoding TxD cycle by cycle against hand-built byte sequences.
module tb_packet_uart_tx;
    localparam int DIV  = 5;
    localparam int FR_H = 23 * 10 * DIV;
    localparam int FR_N = 22 * 10 * DIV;

    logic         clk, rst_n;
    logic [175:0] packet_h, packet_n;
    logic         send_h, send_n;
    logic         busy_h, done_h, txd_h;
    logic         busy_n, done_n, txd_n;

    int vectors;
    int miscompares;

    localparam logic [175:0] P1 = 176'h0102030405060708090A0B0C0D0E0F10111213141516;
    localparam logic [175:0] P2 = 176'hDEADBEEF_00FF_5A3C_0123456789ABCDEF_8001_7E81_C396;
    localparam logic [175:0] P3 = 176'hFFEEDDCCBBAA99887766554433221100_1F2E3D4C5B6A;

    packet_uart_tx #(.CLK_HZ(1000), .BAUD(200), .PKT_BYTES(22), .HDR_EN(1), .HDR_BYTE(8'hA5)) dut_h (
        .clk(clk), .rst_n(rst_n), .packet(packet_h), .send(send_h),
        .busy(busy_h), .done(done_h), .TxD(txd_h)
    );

    packet_uart_tx #(.CLK_HZ(1000), .BAUD(200), .PKT_BYTES(22), .HDR_EN(0), .HDR_BYTE(8'hA5)) dut_n (
        .clk(clk), .rst_n(rst_n), .packet(packet_n), .send(send_n),
        .busy(busy_n), .done(done_n), .TxD(txd_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise send on a negedge; the next negedge must already show the start bit.
    task automatic start_send(input int sel, input logic [175:0] pkt, input bit hold, input string tag);
        if (sel == 0) begin packet_h = pkt; send_h = 1'b1; end
        else begin packet_n = pkt; send_n = 1'b1; end
        @(negedge clk);
        vectors++;
        if (sel == 0) begin
            if (txd_h !== 1'b0 || busy_h !== 1'b1) begin
                miscompares++;
                $display("FAIL %s latency: txd=%b busy=%b, expected txd=0 busy=1", tag, txd_h, busy_h);
            end
            if (!hold) send_h = 1'b0;
        end else begin
            if (txd_n !== 1'b0 || busy_n !== 1'b1) begin
                miscompares++;
                $display("FAIL %s latency: txd=%b busy=%b, expected txd=0 busy=1", tag, txd_n, busy_n);
            end
            if (!hold) send_n = 1'b0;
        end
    endtask

    // Entered at the negedge showing the first start-bit cycle; returns at the done cycle.
    task automatic rx_frame(input int sel, input logic [175:0] pkt, input int abort_at,
                            input int send_at, input int chg_at, input string tag);
        int nbytes;
        int cyc;
        int ok_bytes;
        int bad;
        int p;
        logic [7:0] exp_b, got_b;
        logic [9:0] bits;
        logic t, b, d;
        nbytes = (sel == 0) ? 23 : 22;
        cyc = 0;
        ok_bytes = 0;
        for (int i = 0; i < nbytes; i++) begin
            if (sel == 0 && i == 0) exp_b = 8'hA5;
            else begin
                p = i - ((sel == 0) ? 1 : 0);
                exp_b = pkt[175 - 8*p -: 8];
            end
            bits = {1'b1, exp_b, 1'b0};
            got_b = '0;
            bad = 0;
            for (int j = 0; j < 10; j++) begin
                for (int c = 0; c < DIV; c++) begin
                    if (cyc == abort_at) begin
                        rst_n = 1'b0;
                        #1;
                        vectors++;
                        if (txd_h !== 1'b1 || busy_h !== 1'b0 || done_h !== 1'b0) begin
                            miscompares++;
                            $display("FAIL %s async reset: txd=%b busy=%b done=%b, expected 1 0 0",
                                     tag, txd_h, busy_h, done_h);
                        end
                        $display("frame %s: aborted by reset at cycle %0d after %0d good bytes", tag, cyc, ok_bytes);
                        return;
                    end
                    t = (sel == 0) ? txd_h : txd_n;
                    b = (sel == 0) ? busy_h : busy_n;
                    d = (sel == 0) ? done_h : done_n;
                    if (t !== bits[j] || b !== 1'b1 || d !== 1'b0) bad++;
                    if (j >= 1 && j <= 8 && c == DIV/2) got_b[j-1] = t;
                    if (sel == 0 && send_at >= 0) begin
                        if (cyc == send_at) send_h = 1'b1;
                        if (cyc == send_at + 1) send_h = 1'b0;
                    end
                    if (sel == 0 && chg_at >= 0 && cyc == chg_at) packet_h = '1;
                    cyc++;
                    @(negedge clk);
                end
            end
            vectors++;
            if (got_b !== exp_b || bad != 0) begin
                miscompares++;
                $display("FAIL %s byte%0d: got %h with %0d bad line cycles, expected %h", tag, i, got_b, bad, exp_b);
            end else ok_bytes++;
        end
        t = (sel == 0) ? txd_h : txd_n;
        b = (sel == 0) ? busy_h : busy_n;
        d = (sel == 0) ? done_h : done_n;
        vectors++;
        if (d !== 1'b1 || b !== 1'b0 || t !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done at cycle %0d: done=%b busy=%b txd=%b, expected 1 0 1", tag, cyc, d, b, t);
        end
        $display("frame %s: %0d/%0d bytes ok, done at cycle %0d", tag, ok_bytes, nbytes, cyc);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        send_h = 1'b0; send_n = 1'b0;
        packet_h = '0; packet_n = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (txd_h !== 1'b1 || busy_h !== 1'b0 || done_h !== 1'b0) begin
            miscompares++;
            $display("FAIL reset hdr: txd=%b busy=%b done=%b, expected 1 0 0", txd_h, busy_h, done_h);
        end
        vectors++;
        if (txd_n !== 1'b1 || busy_n !== 1'b0 || done_n !== 1'b0) begin
            miscompares++;
            $display("FAIL reset nohdr: txd=%b busy=%b done=%b, expected 1 0 0", txd_n, busy_n, done_n);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (txd_h !== 1'b1 || busy_h !== 1'b0 || done_h !== 1'b0 ||
                txd_n !== 1'b1 || busy_n !== 1'b0 || done_n !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle watch: %0d cycles not idle, expected 0", bad);
        end
        $display("reset: idle for 10000 cycles checked");
    endtask

    task automatic test_single();
        start_send(0, P1, 1'b0, "single");
        rx_frame(0, P1, -1, -1, -1, "single");
        @(negedge clk);
        vectors++;
        if (done_h !== 1'b0) begin
            miscompares++;
            $display("FAIL single done width: done=%b one cycle later, expected 0", done_h);
        end
    endtask

    task automatic test_ignore_send();
        int bad;
        start_send(0, P1, 1'b0, "ignore");
        rx_frame(0, P1, -1, 200, 300, "ignore");
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy_h !== 1'b0 || txd_h !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL ignore no requeue: %0d active cycles after done, expected 0", bad);
        end
        $display("ignore: post-frame idle checked");
    endtask

    task automatic test_back_to_back();
        int bad;
        start_send(0, P2, 1'b1, "b2b-1");
        rx_frame(0, P2, -1, -1, -1, "b2b-1");
        packet_h = P3;
        @(negedge clk);
        vectors++;
        if (txd_h !== 1'b0 || busy_h !== 1'b1 || done_h !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b restart: txd=%b busy=%b done=%b, expected 0 1 0", txd_h, busy_h, done_h);
        end
        rx_frame(0, P3, -1, -1, -1, "b2b-2");
        send_h = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy_h !== 1'b0 || txd_h !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL b2b stop: %0d active cycles after release, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        start_send(0, P1, 1'b0, "abort");
        rx_frame(0, P1, 7*10*DIV + 4*DIV + 2, -1, -1, "abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_h !== 1'b0 || txd_h !== 1'b1 || done_h !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL abort recovery idle: %0d bad cycles, expected 0", bad);
        end
        start_send(0, P3, 1'b0, "after-abort");
        rx_frame(0, P3, -1, -1, -1, "after-abort");
    endtask

    task automatic test_no_header();
        start_send(1, 176'd0, 1'b0, "nohdr");
        rx_frame(1, 176'd0, -1, -1, -1, "nohdr");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_ignore_send();
        test_back_to_back();
        test_reset_mid();
        test_no_header();
        $display("frame lengths exercised: %0d and %0d cycles", FR_H, FR_N);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
